// File: rtl/wb_sram_pkg.sv
// rtl/wb_sram_pkg.sv - shared types and constants for the 16-bit SRAM bridge
package wb_sram_pkg;

  localparam int WCNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_ACK
  } sram_state_t;

  // States in which the SRAM is selected and address/data are driven
  function automatic logic is_bus_phase(input sram_state_t s);
    return (s == S_SETUP) || (s == S_STROBE) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/if_wb.sv
// rtl/if_wb.sv - pipelined Wishbone bus bundle
interface if_wb;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_m;
  logic [31:0] dat_s;
  logic        ack;
  logic        stall;

  modport slave  (input cyc, stb, we, adr, sel, dat_m, output dat_s, ack, stall);
  modport master (output cyc, stb, we, adr, sel, dat_m, input dat_s, ack, stall);
endinterface

// File: rtl/wb_sram16.sv
// rtl/wb_sram16.sv - Wishbone word slave driving a 16-bit asynchronous SRAM
module wb_sram16
  import wb_sram_pkg::*;
#(
  parameter int AWIDTH = 20,
  parameter int WAIT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  if_wb.slave               bus,
  output logic [AWIDTH-1:0] sram_adr,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_lb_n,
  output logic              sram_ub_n
);

  localparam logic [WCNT_W-1:0] WAIT_LD = WCNT_W'(WAIT);

  sram_state_t       r_state, w_state_nxt;
  logic              r_half, w_half_nxt;
  logic              r_we;
  logic [AWIDTH-2:0] r_adr;
  logic [3:0]        r_sel;
  logic [31:0]       r_wdat;
  logic [WCNT_W-1:0] r_wcnt;
  logic [15:0]       r_rlo;
  logic [31:0]       r_rdat;
  logic              r_abort;

  logic              w_accept, w_last, w_bus_nxt;
  logic              w_we;
  logic [AWIDTH-2:0] w_adr;
  logic [3:0]        w_sel;
  logic [31:0]       w_dat;
  logic              w_ce_n, w_oe_n, w_we_n, w_lb_n, w_ub_n, w_dq_oe;
  logic [15:0]       w_dq_o;
  logic [AWIDTH-1:0] w_sram_adr;
  logic              w_unused;

  assign w_unused = &{1'b0, bus.adr[31:AWIDTH+1], bus.adr[1:0]};

  // Request fields come straight off the bus on the accept cycle, from the latch afterwards
  assign w_accept = (r_state == S_IDLE) && bus.cyc && bus.stb;
  assign w_we     = w_accept ? bus.we              : r_we;
  assign w_adr    = w_accept ? bus.adr[AWIDTH:2]   : r_adr;
  assign w_sel    = w_accept ? bus.sel             : r_sel;
  assign w_dat    = w_accept ? bus.dat_m           : r_wdat;
  assign w_last   = (r_wcnt == '0);

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
      r_half  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_half  <= w_half_nxt;
    end
  end

  // Next-state and halfword selection
  always_comb begin
    w_state_nxt = r_state;
    w_half_nxt  = r_half;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!bus.we || (bus.sel[1:0] != 2'b00)) begin
            w_state_nxt = S_SETUP;
            w_half_nxt  = 1'b0;
          end else if (bus.sel[3:2] != 2'b00) begin
            w_state_nxt = S_SETUP;
            w_half_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ACK;
          end
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: begin
        if (w_last) begin
          if (r_we) begin
            w_state_nxt = S_HOLD;
          end else if (!r_half) begin
            w_state_nxt = S_SETUP;
            w_half_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ACK;
          end
        end
      end
      S_HOLD: begin
        if (!r_half && (r_sel[3:2] != 2'b00)) begin
          w_state_nxt = S_SETUP;
          w_half_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_ACK;
        end
      end
      S_ACK:    w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // SRAM pin values decoded from the state being entered, so the pin flops change on entry
  always_comb begin
    w_bus_nxt  = is_bus_phase(w_state_nxt);
    w_ce_n     = !w_bus_nxt;
    w_oe_n     = !((w_state_nxt == S_STROBE) && !w_we);
    w_we_n     = !((w_state_nxt == S_STROBE) && w_we);
    w_dq_oe    = w_bus_nxt && w_we;
    w_lb_n     = 1'b1;
    w_ub_n     = 1'b1;
    w_dq_o     = sram_dq_o;
    w_sram_adr = sram_adr;
    if (w_bus_nxt) begin
      w_sram_adr = {w_adr, w_half_nxt};
      if (w_we) begin
        w_lb_n = w_half_nxt ? !w_sel[2] : !w_sel[0];
        w_ub_n = w_half_nxt ? !w_sel[3] : !w_sel[1];
        w_dq_o = w_half_nxt ? w_dat[31:16] : w_dat[15:0];
      end else begin
        w_lb_n = 1'b0;
        w_ub_n = 1'b0;
      end
    end
  end

  // SRAM pin flops; reset releases every control immediately
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      sram_dq_o  <= '0;
      sram_adr   <= '0;
    end else begin
      sram_ce_n  <= w_ce_n;
      sram_oe_n  <= w_oe_n;
      sram_we_n  <= w_we_n;
      sram_lb_n  <= w_lb_n;
      sram_ub_n  <= w_ub_n;
      sram_dq_oe <= w_dq_oe;
      sram_dq_o  <= w_dq_o;
      sram_adr   <= w_sram_adr;
    end
  end

  // Request latch and abandoned-cycle flag (sequence completes, ack is withheld)
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_sel   <= '0;
      r_wdat  <= '0;
      r_abort <= 1'b0;
    end else if (w_accept) begin
      r_we    <= bus.we;
      r_adr   <= bus.adr[AWIDTH:2];
      r_sel   <= bus.sel;
      r_wdat  <= bus.dat_m;
      r_abort <= 1'b0;
    end else if ((r_state != S_IDLE) && !bus.cyc) begin
      r_abort <= 1'b1;
    end
  end

  // Strobe wait counter: loaded in setup, counts down through the strobe
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wcnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wcnt <= WAIT_LD;
    end else if ((r_state == S_STROBE) && !w_last) begin
      r_wcnt <= r_wcnt - 1'b1;
    end
  end

  // Read capture; the visible word updates only when the high half lands
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rlo  <= '0;
      r_rdat <= '0;
    end else if ((r_state == S_STROBE) && w_last && !r_we) begin
      if (!r_half) r_rlo  <= sram_dq_i;
      else         r_rdat <= {sram_dq_i, r_rlo};
    end
  end

  assign bus.stall = (r_state != S_IDLE);
  assign bus.ack   = (r_state == S_ACK) && bus.cyc && !r_abort;
  assign bus.dat_s = r_rdat;

endmodule

// File: doc/wb_sram16.md
# wb_sram16

- Wishbone pipelined slave that bridges 32-bit word accesses onto a 16-bit external asynchronous SRAM.
- Sits directly downstream of the cache's outbus.
- Serves the cache's single-word fill and flush cycles: two halfword SRAM cycles per word, with a programmable number of strobe wait states and byte-lane masking on writes.

## Interface
- AWIDTH, 20: SRAM halfword address width. Wishbone word address is adr[AWIDTH:2].
- WAIT, 2: extra strobe cycles per halfword access. Legal range 0..15.
- clk_i  in  1  system clock. All flops on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- bus  if_wb.slave  —  cyc, stb, we, adr[31:0], sel[3:0], dat_m[31:0] in; dat_s[31:0], ack, stall out.
- sram_adr  out  AWIDTH  halfword address.
- sram_dq_i  in  16  read data from pad.
- sram_dq_o  out  16  write data to pad.
- sram_dq_oe  out  1  pad output enable, active-high.
- sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n  out  1 each  active-low SRAM controls.

## Operation
- States: S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_ACK. Register `half` selects the halfword: 0 = low, 1 = high.
- Halfword mapping:
  - half 0 = dat[15:0], sel[1:0], sram_adr = {adr[AWIDTH:2], 1'b0}.
  - half 1 = dat[31:16], sel[3:2], sram_adr = {adr[AWIDTH:2], 1'b1}.
- S_IDLE: stall low. On cyc&stb, latch we, adr, sel, dat_m.
  - Reads, and writes with sel[1:0]!=0: go to S_SETUP with half=0.
  - Writes with sel[1:0]==0 and sel[3:2]!=0: go to S_SETUP with half=1.
  - Writes with sel==0: go to S_ACK.
- S_SETUP, 1 cycle:
  - ce_n low; address valid; oe_n and we_n high.
  - Writes drive dq_o and dq_oe=1.
  - lb_n/ub_n = ~sel pair on writes, 0/0 on reads.
  - Load wait counter with WAIT, then go to S_STROBE.
- S_STROBE, WAIT+1 cycles:
  - Reads: oe_n low. Writes: we_n low.
  - On the last cycle (counter==0), reads capture sram_dq_i into the selected half of the data register.
  - Exit: writes go to S_HOLD. Reads go to S_SETUP with half=1 if half==0, else S_ACK.
- S_HOLD (writes only), 1 cycle: we_n high; ce_n, address and dq still driven. Exit:
  - half==0 and sel[3:2]!=0: S_SETUP with half=1.
  - Otherwise: S_ACK.
- S_ACK, 1 cycle:
  - ack = cyc. dat_s holds the assembled read word, stable until the next read completes.
  - All SRAM controls are inactive. Go to S_IDLE.
- stall = (state != S_IDLE). The next request is accepted no earlier than the cycle after ack.
- cyc dropping mid-transaction does not abort the SRAM sequence, so no torn halfword write occurs. In that case ack is suppressed in S_ACK.
- adr[1:0] and adr bits above AWIDTH are ignored.

## Timing
- Every SRAM output is a flop loaded from next-state decode, so it changes exactly on state entry and is glitch-free.
- Reset values:
  - ce_n, oe_n, we_n, lb_n, ub_n = 1.
  - dq_oe = 0; dq_o = 0; sram_adr = 0.
  - dat_s = 0; ack = 0; stall = 0; state = S_IDLE.
- Reset assertion mid-access releases all SRAM controls asynchronously, in the same cycle.
- Latency, counting the cycle where stb is accepted as cycle 0:
  - Read: ack in cycle 2*WAIT+5 (9 at WAIT=2).
  - Full write: ack in cycle 2*WAIT+7 (11).
  - Single-half write: ack in cycle WAIT+4 (6).
  - sel==0 write: ack in cycle 1.
- Wait counter width: 4 bits. WAIT=0 gives a one-cycle strobe.
- we_n is never low in the same cycle that address or dq changes: setup and hold cycles bracket every write strobe.

## Structure
- Package wb_sram_pkg holds the state typedef sram_state_t and the localparam WCNT_W=4.
- No sub-module. The counter and data register are inline.
- The bidirectional pad (dq_o/dq_oe/dq_i) is resolved at the board top, not in this block.

## Test plan
- Reset, then idle: all *_n outputs = 1, dq_oe=0, stall=0, ack=0.
- Write adr=0x104, dat=0xDEADBEEF, sel=0xF, WAIT=2:
  - SRAM model sees halfword 0x82 = 0xBEEF, then 0x83 = 0xDEAD.
  - we_n low exactly 3 cycles each, ack in cycle 11.
- Read back adr=0x104: dat_s=0xDEADBEEF with ack in cycle 9; stall high from cycle 1 to 9.
- Write sel=0x4, dat=0x00AA0000 over 0xDEADBEEF:
  - Only the high halfword is accessed, with lb_n=0 and ub_n=1; ack in cycle 6.
  - A subsequent read returns 0xDEAABEEF.
- Drop cyc during the low-half strobe of a write: both halves are still written, no ack pulses, and the next request is accepted.
- Assert rst_i low mid-strobe: we_n/ce_n go high and dq_oe low in the same cycle; state returns to S_IDLE.
